rr_mux: RTL
===========

Name: rr_mux

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and a valid/ready handshake on every channel. Round-robin arbitration among requesting channels replaces the static select of the single-cycle datapath mux. Used where several producers share one consumer, e.g. instruction fetch and load/store sharing a single memory port.

Parameters:
WIDTH, 32, data width per channel in bits
N, 2, number of input channels; legal range 2..16
SEL_W, $clog2(N), width of the granted-channel index; derived, do not override

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-high
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  channel i presents a word
in_ready  output  N  channel i word accepted this cycle when in_valid[i] & in_ready[i]
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts out_data this cycle
out_sel  output  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready follows combinationally, so it is 0 while rst is high.
- Output slot is one register. The slot is free when out_valid=0 or (out_valid & out_ready).
- Arbitration is combinational. Scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1. The first one with in_valid set is the grant g. If no channel is valid, there is no grant.
- in_ready[i] = slot free & grant exists & (i==g). At most one in_ready bit is high in any cycle. in_ready does not depend on out_ready except through the slot-free term.
- On accept (slot free & grant): out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=(g==N-1)?0:g+1. Wrap applies for any N, including non-power-of-2.
- On drain without accept (out_valid & out_ready, no grant): out_valid<=0. out_data and out_sel hold their last values.
- Simultaneous drain and accept in the same cycle: the new word is loaded and out_valid stays 1. This gives full throughput of one word per cycle.
- Stall (out_valid & ~out_ready): all in_ready=0. out_data, out_sel and ptr hold.
- Latency: one cycle from input handshake to out_valid.
- ptr changes only on accept. Idle cycles leave ptr unchanged.
- Producers must hold in_data/in_valid stable until accepted. Dropping in_valid before acceptance is allowed; the channel simply stops competing.
- rst asserted mid-transfer discards the held word immediately (out_valid=0) and returns ptr to 0.

Optional Feature:
RR_MUX_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index valid channel always wins, and the ptr register is not instantiated. All handshake, latency and reset rules are unchanged.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. Reset. Assert rst with in_valid=2'b11 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. After release, the first accept goes to channel 0 (ptr=0).
2. Fairness. N=2, both channels valid continuously, in0=32'hFFFFFFFF, in1=32'hEEEEEEEE, out_ready=1 -> out_sel alternates 0,1,0,1 and out_data alternates accordingly, with out_valid=1 every cycle after the first.
3. Backpressure. Hold out_ready=0 for 3 cycles while out_data=32'h01234567 -> out_data/out_sel stable and in_ready=0 throughout. Raise out_ready -> 32'h89ABCDEF from the pending channel appears the next cycle.
4. Wrap with non-power-of-2 depth. N=3, only channel 2 valid, then all three valid -> grants 2 then 0,1,2,0. ptr wraps from 2 to 0.
5. Mid-operation reset. Assert rst while out_valid=1 and out_ready=0 -> out_valid drops asynchronously in the same cycle, and the next grant after release starts from channel 0.
6. Macro build. With RR_MUX_FIXED_PRIO_EN defined and both channels valid, out_ready=1 -> out_sel=0 every cycle. Channel 1 is served only when in_valid[0]=0.

Source files
------------

// File: rtl/rr_mux.sv
// rr_mux: N-channel, WIDTH-bit multiplexer with a single registered output
// slot and a valid/ready handshake on every input channel. The channel that
// fills the slot is chosen by round-robin arbitration among requesters.
//
// Build option:
//   RR_MUX_FIXED_PRIO_EN - when defined, the lowest-index valid channel always
//                          wins and no round-robin pointer is kept.
module rr_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 2,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
);

  localparam int unsigned NU = N;

  logic             slot_free;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic             accept;
  logic [WIDTH-1:0] grant_data;

`ifdef RR_MUX_FIXED_PRIO_EN

  // Fixed priority: the first valid channel counting up from 0 wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (!grant_vld && in_valid[SEL_W'(k)]) begin
        grant_vld = 1'b1;
        grant     = SEL_W'(k);
      end
    end
  end

`else

  logic [SEL_W-1:0] ptr;

  // Round-robin: scan ptr, ptr+1, ... wrapping at N; first valid channel wins.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NU) begin
        idx = idx - NU;
      end
      if (!grant_vld && in_valid[SEL_W'(idx)]) begin
        grant_vld = 1'b1;
        grant     = SEL_W'(idx);
      end
    end
  end

  // Pointer advances past the winner only when a word is actually taken;
  // the explicit compare against N-1 handles non-power-of-2 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      if (grant == SEL_W'(N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant + 1'b1;
      end
    end
  end

`endif

  // Slot is free when empty or being drained this cycle.
  always_comb begin
    slot_free = ~out_valid | out_ready;
    accept    = slot_free & grant_vld & ~rst;
  end

  // Select the granted channel's word and raise its ready bit only.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = accept;
      end
    end
  end

  // Output slot: load on accept, clear valid on drain without accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
